// File: rtl/io_host_bridge.sv
// Host-side bridge for the MCU 8-bit I/O port: change-captured TX FIFO and held RX byte.
// Optional echo of the MCU output back to its input when IO_BRIDGE_LOOPBACK_EN is defined.
module io_host_bridge #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               mcu_io_output,
    output logic [7:0]               mcu_io_input,
    output logic [7:0]               host_tx_data,
    output logic                     host_tx_valid,
    input  logic                     host_tx_ready,
    input  logic [7:0]               host_rx_data,
    input  logic                     host_rx_valid,
    output logic                     host_rx_ready,
`ifdef IO_BRIDGE_LOOPBACK_EN
    input  logic                     loopback,
`endif
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {
        RX_IDLE,
        RX_HOLD
    } rx_state_t;

    logic [7:0]    last_seen;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          changed;
    logic          full;
    logic          pop;
    logic          do_push;
    logic          drop;

    rx_state_t     rx_state;
    logic [HW-1:0] hold_cnt;
    logic [7:0]    rx_hold;

    assign changed = (mcu_io_output != last_seen);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop     = (count != '0) && host_tx_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign do_push = changed && (!full || pop);
    assign drop    = changed && full && !pop;

    assign host_tx_data  = mem[rd_ptr];
    assign host_tx_valid = (count != '0);
    assign tx_count      = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_seen <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (changed) begin
                last_seen <= mcu_io_output;
            end
            if (do_push) begin
                mem[wr_ptr] <= mcu_io_output;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !pop) begin
                count <= count + 1'b1;
            end else if (!do_push && pop) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state      <= RX_IDLE;
            hold_cnt      <= '0;
            rx_hold       <= '0;
            host_rx_ready <= 1'b1;
        end else begin
            unique case (rx_state)
                RX_IDLE: begin
                    if (host_rx_valid) begin
                        rx_hold       <= host_rx_data;
                        hold_cnt      <= HW'(HOLD_CYCLES - 1);
                        host_rx_ready <= 1'b0;
                        rx_state      <= RX_HOLD;
                    end
                end
                RX_HOLD: begin
                    if (hold_cnt == '0) begin
                        host_rx_ready <= 1'b1;
                        rx_state      <= RX_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

`ifdef IO_BRIDGE_LOOPBACK_EN
    assign mcu_io_input = loopback ? last_seen : rx_hold;
`else
    assign mcu_io_input = rx_hold;
`endif

endmodule
